// File: rtl/fmul_pkg.sv
// Float word layout shared by the fmul core and the requester-sharing arbiter.
// The word is 19 bits: a 2-bit exception field, then sign, 8-bit exponent and 8-bit fraction.
package fmul_pkg;

    localparam int unsigned FP_W     = 19;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FRAC_W   = 8;
    localparam int unsigned EXP_BIAS = 127;

    localparam int unsigned EXC_HI  = 18;
    localparam int unsigned EXC_LO  = 17;
    localparam int unsigned SIGN    = 16;
    localparam int unsigned EXP_HI  = 15;
    localparam int unsigned EXP_LO  = 8;
    localparam int unsigned FRAC_HI = 7;
    localparam int unsigned FRAC_LO = 0;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    typedef struct packed {
        logic [1:0]        exc;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_word_t;

    function automatic logic [1:0] exc_of(input fp_word_t w);
        return w.exc;
    endfunction

endpackage

// File: rtl/fmul_result_fifo.sv
// First-word-fall-through result buffer for tagged products.
// The head entry is always visible on out_data, and out_valid is high whenever the buffer is non-empty.
module fmul_result_fifo
    import fmul_pkg::*;
#(
    parameter int unsigned WIDTH = FP_W + 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             pop_ok;

    assign pop_ok    = pop && (count != '0);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    // Storage is cleared on reset so the exposed head reads zero when empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            assert (!(push && (count == CW'(DEPTH))));
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (32'(wr_ptr) == DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (32'(rd_ptr) == DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            end
            if (push && !pop_ok) begin
                count <= count + CW'(1);
            end else if (!push && pop_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fmul_share_arbiter.sv
// Shares one non-stallable pipelined fmul core among NREQ requesters. Arbitration is round-robin.
// Results are tagged and delivered in order through a credit-protected result buffer.
module fmul_share_arbiter
    import fmul_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LAT   = 1,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = FP_W,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [W-1:0]      mul_x,
    output logic [W-1:0]      mul_y,
    input  logic [W-1:0]      mul_r,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [W-1:0]      resp_r,
    output logic [IDW-1:0]    resp_id
);
    localparam int unsigned EW = W + IDW;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [IDW-1:0] rr_ptr;
    logic [LAT-1:0] tag_v;
    logic [IDW-1:0] tag_id [LAT];
    logic [CW-1:0]  fifo_count;
    logic [EW-1:0]  fifo_out;
    logic [IDW-1:0] grant;
    logic           any_valid;
    logic           can_issue;
    logic           issue;
    logic           pop;
    int unsigned    occ;
    int unsigned    idx;

    // Credits cover both buffered results and products still inside the core.
    always_comb begin
        occ = 32'(fifo_count);
        for (int i = 0; i < LAT; i++) begin
            occ = occ + 32'(tag_v[i]);
        end
    end

    assign can_issue = (occ < DEPTH);

    // Cyclic first-valid search starting at rr_ptr.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr) + 32'(k)) % NREQ;
            if (!any_valid && req_valid[IDW'(idx)]) begin
                any_valid = 1'b1;
                grant     = IDW'(idx);
            end
        end
    end

    assign issue     = can_issue && any_valid && rst_n;
    assign req_ready = issue ? (NREQ'(1) << grant) : '0;
    assign mul_x     = issue ? req_x[32'(grant) * W +: W] : '0;
    assign mul_y     = issue ? req_y[32'(grant) * W +: W] : '0;
    assign pop       = resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            tag_v  <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            if (issue) begin
                rr_ptr <= (32'(grant) == NREQ - 1) ? '0 : grant + IDW'(1);
            end
            tag_v[0]  <= issue;
            tag_id[0] <= grant;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    fmul_result_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_v[LAT-1]),
        .push_data ({tag_id[LAT-1], mul_r}),
        .pop       (pop),
        .out_valid (resp_valid),
        .out_data  (fifo_out),
        .count     (fifo_count)
    );

    assign {resp_id, resp_r} = fifo_out;

endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Directed bench for fmul_share_arbiter with a behavioural fmul core model on the core port.
// Expected words are hand-computed constants.
module tb_fmul_share_arbiter;
    import fmul_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 19;
    localparam int unsigned IDW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [W-1:0]      mul_x;
    logic [W-1:0]      mul_y;
    logic [W-1:0]      mul_r;
    logic              resp_valid;
    logic              resp_ready;
    logic [W-1:0]      resp_r;
    logic [IDW-1:0]    resp_id;

    int checks = 0;
    int errors = 0;
    int denied = 0;
    int max_denied = 0;

    logic [W-1:0] core_pipe [LAT];

    always #5 clk = ~clk;

    fmul_share_arbiter #(
        .NREQ  (NREQ),
        .LAT   (LAT),
        .DEPTH (DEPTH),
        .W     (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_r      (mul_r),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_r     (resp_r),
        .resp_id    (resp_id)
    );

    // Behavioural multiplier with truncating rounding, adequate for the directed operands.
    function automatic logic [18:0] fmul_model(input logic [18:0] x, input logic [18:0] y);
        logic [1:0]  ex;
        logic [1:0]  ey;
        logic        s;
        logic [17:0] p;
        logic [7:0]  frac;
        int          e;
        ex = x[18:17];
        ey = y[18:17];
        s  = x[16] ^ y[16];
        if (ex == EXC_NAN || ey == EXC_NAN || (ex == EXC_INF && ey == EXC_ZERO) ||
            (ex == EXC_ZERO && ey == EXC_INF)) return {EXC_NAN, s, 16'h0};
        if (ex == EXC_INF || ey == EXC_INF) return {EXC_INF, s, 16'h0};
        if (ex == EXC_ZERO || ey == EXC_ZERO) return {EXC_ZERO, s, 16'h0};
        p = 18'({1'b1, x[7:0]}) * 18'({1'b1, y[7:0]});
        e = int'(x[15:8]) + int'(y[15:8]) - 127;
        if (p[17]) begin
            e    = e + 1;
            frac = p[16:9];
        end else begin
            frac = p[15:8];
        end
        if (e >= 255) return {EXC_INF, s, 16'h0};
        if (e <= 0) return {EXC_ZERO, s, 16'h0};
        return {EXC_NORMAL, s, 8'(e), frac};
    endfunction

    always_ff @(posedge clk) begin
        core_pipe[0] <= fmul_model(mul_x, mul_y);
        for (int i = 1; i < LAT; i++) begin
            core_pipe[i] <= core_pipe[i-1];
        end
    end
    assign mul_r = core_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rn, input logic rdy, input logic [NREQ-1:0] v);
        @(negedge clk);
        rst_n      = rn;
        resp_ready = rdy;
        req_valid  = v;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b1, '0);
    endtask

    initial begin
        rst_n      = 1'b0;
        resp_ready = 1'b0;
        req_valid  = '1;
        req_x      = '0;
        req_y      = '0;

        // Reset state with every requester asserting valid
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_r", 32'(resp_r), 0);
        check("rst_resp_id", 32'(resp_id), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_mul_x", 32'(mul_x), 0);

        // Test 1: single request, 1.0 * 2.0
        cyc(1'b1, 1'b1, '0);
        cyc(1'b1, 1'b1, 4'b0001);
        set_op(0, 19'h27F00, 19'h28000);
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        check("t1_mul_x", 32'(mul_x), 32'h27F00);
        check("t1_mul_y", 32'(mul_y), 32'h28000);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t1_no_early_resp", 32'(resp_valid), 0);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t1_resp_valid", 32'(resp_valid), 1);
        check("t1_resp_r", 32'(resp_r), 32'h28000);
        check("t1_resp_id", 32'(resp_id), 0);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t1_drained", 32'(resp_valid), 0);

        // Test 2: all requesters busy, 1.5 * 1.5 each
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 19'h27F80, 19'h27F80);
        for (int c = 0; c < 10; c++) begin
            cyc(1'b1, 1'b1, (c < 8) ? 4'hF : 4'h0);
            #1;
            if (c < 8) check("t2_grant", 32'(req_ready), 32'(1) << (c % 4));
            if (c >= 2) begin
                check("t2_resp_valid", 32'(resp_valid), 1);
                check("t2_resp_id", 32'(resp_id), 32'((c - 2) % 4));
                check("t2_resp_r", 32'(resp_r), 32'h28020);
            end
        end
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t2_drained", 32'(resp_valid), 0);

        // Test 3: consumer stalled, credits run out after DEPTH issues
        do_reset();
        set_op(1, 19'h27F00, 19'h28000);
        set_op(2, 19'h27F80, 19'h27F80);
        for (int c = 0; c < 6; c++) begin
            cyc(1'b1, 1'b0, 4'b0110);
            #1;
            if (c < 4) check("t3_grant", 32'(req_ready), (c % 2 == 0) ? 32'h2 : 32'h4);
            else begin
                check("t3_blocked", 32'(req_ready), 0);
                check("t3_hold_id", 32'(resp_id), 1);
                check("t3_hold_r", 32'(resp_r), 32'h28000);
            end
        end
        cyc(1'b1, 1'b1, 4'b0110);
        #1;
        check("t3_no_bypass", 32'(req_ready), 0);
        check("t3_d0_id", 32'(resp_id), 1);
        check("t3_d0_r", 32'(resp_r), 32'h28000);
        cyc(1'b1, 1'b1, 4'b0110);
        #1;
        check("t3_resume", 32'(req_ready), 32'h2);
        check("t3_d1_id", 32'(resp_id), 2);
        check("t3_d1_r", 32'(resp_r), 32'h28020);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t3_d2_id", 32'(resp_id), 1);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t3_d3_id", 32'(resp_id), 2);
        check("t3_d3_r", 32'(resp_r), 32'h28020);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t3_d4_valid", 32'(resp_valid), 1);
        check("t3_d4_id", 32'(resp_id), 1);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t3_drained", 32'(resp_valid), 0);

        // Test 4: exception words pass through
        do_reset();
        cyc(1'b1, 1'b1, 4'b0001);
        set_op(0, 19'h40000, 19'h00000);
        #1;
        check("t4_grant0", 32'(req_ready), 32'h1);
        cyc(1'b1, 1'b1, 4'b0001);
        set_op(0, 19'h00000, 19'h27F00);
        #1;
        check("t4_grant1", 32'(req_ready), 32'h1);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t4_nan_valid", 32'(resp_valid), 1);
        check("t4_nan_exc", 32'(resp_r[EXC_HI:EXC_LO]), 32'(EXC_NAN));
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t4_zero_valid", 32'(resp_valid), 1);
        check("t4_zero_exc", 32'(resp_r[EXC_HI:EXC_LO]), 32'(EXC_ZERO));
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t4_drained", 32'(resp_valid), 0);

        // Test 5: reset while one result is in the core and two are buffered
        do_reset();
        set_op(1, 19'h27F00, 19'h28000);
        set_op(2, 19'h27F80, 19'h27F80);
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 1'b0, 4'b0100);
            #1;
            check("t5_issue", 32'(req_ready), 32'h4);
        end
        cyc(1'b0, 1'b0, 4'b0100);
        #1;
        check("t5_ready_in_reset", 32'(req_ready), 0);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t5_valid_after_rst", 32'(resp_valid), 0);
        check("t5_r_after_rst", 32'(resp_r), 0);
        check("t5_id_after_rst", 32'(resp_id), 0);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t5_no_stale0", 32'(resp_valid), 0);
        cyc(1'b1, 1'b1, 4'b1010);
        #1;
        check("t5_rr_restart", 32'(req_ready), 32'h2);
        check("t5_no_stale1", 32'(resp_valid), 0);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t5_no_stale2", 32'(resp_valid), 0);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t5_new_valid", 32'(resp_valid), 1);
        check("t5_new_id", 32'(resp_id), 1);
        check("t5_new_r", 32'(resp_r), 32'h28000);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t5_drained", 32'(resp_valid), 0);

        // Test 6: fairness with requester 0 toggling and requester 3 steady
        do_reset();
        for (int c = 0; c < 16; c++) begin
            cyc(1'b1, 1'b1, (c % 2 == 0) ? 4'b1001 : 4'b1000);
            #1;
            check("t6_grant", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h8);
            if (req_ready != '0) begin
                if (req_ready[3]) denied = 0;
                else begin
                    denied++;
                    if (denied > max_denied) max_denied = denied;
                end
            end
        end
        check("t6_fair", 32'(max_denied <= int'(NREQ - 1)), 1);
        cyc(1'b1, 1'b1, '0);
        cyc(1'b1, 1'b1, '0);
        cyc(1'b1, 1'b1, '0);
        #1;
        check("t6_drained", 32'(resp_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fmul_share_arbiter.md
Name: fmul_share_arbiter

Overview:
- Shares one pipelined fmul core (8-bit exponent, 8-bit fraction, 19-bit FloPoCo word with 2-bit exception field) among NREQ requesters.
- Requesters use a valid/ready handshake. A round-robin arbiter issues at most one operand pair per cycle.
- Each requester ID is tracked through the core latency. Tagged results are buffered in a credit-protected result FIFO, because the core cannot stall.
- Sits between the scheduled datapath lanes and a single fmul instance.

Parameters:
- NREQ, 4, number of requesters (2..16)
- LAT, 1, fmul core latency in cycles, from operands presented to R valid
- DEPTH, 4, result FIFO depth; also the credit limit (≥ LAT+1)
- W, 19, float word width
- IDW, $clog2(NREQ), requester ID width (derived; do not override)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_x  in  NREQ*W  packed X operands, requester i at [i*W +: W]
- req_y  in  NREQ*W  packed Y operands
- mul_x  out  W  to fmul X
- mul_y  out  W  to fmul Y
- mul_r  in  W  from fmul R
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_r  out  W  product word
- resp_id  out  IDW  originating requester

Behaviour:
- Reset (rst_n low at a clock edge):
  - rr_ptr=0, tag pipe cleared, FIFO empty.
  - resp_valid=0, resp_r=0, resp_id=0.
  - req_ready forced 0 while rst_n low.
  - Results in flight when reset is asserted are discarded, including reset mid-operation.
- Credits:
  - occ = FIFO occupancy + number of valid tag-pipe stages.
  - can_issue = (occ < DEPTH).
  - No same-cycle bypass: a pop in cycle t frees the credit from t+1.
- Arbitration:
  - grant = the first i with req_valid[i], searching cyclically from rr_ptr.
  - issue = can_issue & |req_valid.
  - req_ready = issue ? onehot(grant) : 0. req_ready may depend combinationally on req_valid; requesters must not make valid depend on ready.
  - On issue, rr_ptr <= (grant+1) mod NREQ. Otherwise rr_ptr holds.
- Core drive (combinational):
  - mul_x/mul_y = the granted operands when issue, else 0 (all-zero word, exc=00).
- Tag pipe:
  - LAT-deep shift register of {valid, id}; stage 0 loads {issue, grant}.
  - When the stage LAT-1 output is valid, push {id, mul_r} into the FIFO in that cycle, i.e. LAT cycles after issue.
- FIFO:
  - DEPTH entries, first-word-fall-through, registered outputs.
  - resp_valid = !empty.
  - Pop on resp_valid & resp_ready.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - Push when full is impossible by credit construction; assert this in simulation.
  - resp_r and resp_id hold stable while resp_valid & !resp_ready.
- Latency:
  - Minimum issue-to-resp_valid is LAT+1 cycles (LAT in core, 1 in FIFO write).
  - Results are delivered strictly in issue order.
- Throughput:
  - One issue per cycle while resp_ready is high and credits are available.
  - With resp_ready low, at most DEPTH issues, then all req_ready=0 until a pop.
- Arithmetic: none in this block; words pass through unmodified.

Decomposition:
- Package fmul_pkg:
  - FP_W=19, EXP_W=8, FRAC_W=8.
  - Field offsets: EXC_HI=18, EXC_LO=17, SIGN=16, EXP 15:8, FRAC 7:0.
  - Exception encodings: EXC_ZERO=2'b00, EXC_NORMAL=2'b01, EXC_INF=2'b10, EXC_NAN=2'b11.
  - EXP_BIAS=127.
  - Typedef fp_word_t.
- Sub-module fmul_result_fifo: parameterised width (W+IDW) and DEPTH, FWFT, exposes count.
- The arbiter, credit counter and tag pipe stay in the top module.

Test Plan:
1. Single requester 0 sends X=0x27F00 (1.0), Y=0x28000 (2.0) at t=0, resp_ready=1 -> req_ready[0]=1 at t=0; resp_valid at t=LAT+1=2 with resp_r=0x28000, resp_id=0.
2. All four requesters valid every cycle, each with X=Y=0x27F80 (1.5), resp_ready=1 -> grants 0,1,2,3,0,… one per cycle; each resp_r=0x28020 (2.25); resp_id sequence 0,1,2,3,0.
3. resp_ready=0, requesters 1 and 2 continuously valid -> exactly DEPTH=4 issues (1,2,1,2), then req_ready=0. Raise resp_ready -> ids 1,2,1,2 drained in order, and issue resumes one cycle after the first pop.
4. Exceptions: X=0x40000 (+inf), Y=0x00000 (zero) -> resp_r[18:17]=2'b11. X=0x00000 × Y=0x27F00 -> resp_r[18:17]=2'b00.
5. Reset mid-operation: issue 3 requests, drop rst_n for 1 cycle while one is in the tag pipe and two are in the FIFO -> resp_valid=0 the cycle after reset, no stale response ever appears, and rr_ptr restarts at 0 (first grant goes to the lowest valid index).
6. Fairness: requester 3 held valid while requester 0 toggles valid every cycle -> requester 3 is never denied for more than NREQ-1 consecutive issue cycles.
